// File: rtl/gtype.sv
// gtype: shared XGMII word types
package gtype;
  typedef struct packed {
    logic        ena;
    logic [3:0]  ctrl;
    logic [31:0] data;
  } xgmii32_t;
endpackage

// File: rtl/xgmii_tx_32b_framer.sv
// xgmii_tx_32b_framer: frames a byte-stream packet into 32-bit XGMII words with deficit idle count
module xgmii_tx_32b_framer
  import gtype::*;
#(
  parameter int IPG_BYTES = 12
) (
  input  logic        clk_tx,
  input  logic        rst,
  input  logic        ena,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        s_sop,
  input  logic        s_eop,
  input  logic [1:0]  s_empty,
  output xgmii32_t    tx,
  output logic        frame_done,
  output logic        err_underrun,
  output logic        err_framing
);
  typedef enum logic [2:0] {IDLE, PRE, DATA, TERM, GAP, DROP} state_t;
  localparam logic [31:0] IDLE_W = 32'h07070707;
  localparam logic [7:0]  IPG    = 8'(IPG_BYTES);
  localparam logic [7:0]  IPG_W  = 8'((IPG_BYTES + 3) / 4);
  state_t      state, state_nx;
  logic [1:0]  dic, dic_nx;
  logic [7:0]  ipg_cnt, ipg_nx, sum;
  logic [31:0] data_nx, term_data;
  logic [3:0]  ctrl_nx, term_ctrl;
  logic [2:0]  v, t;
  logic        term, done_nx, urun_nx, fram_nx;
  assign s_ready = ena & (state == DATA | state == DROP | (state == IDLE & s_valid & !s_sop));
  assign v   = 3'd4 - {1'b0, s_empty};
  assign t   = state == TERM ? 3'd4 : {1'b0, s_empty};
  // IPG_BYTES >= 8 keeps dic + IPG - t positive, so k = sum/4 and the remainder is the new deficit
  assign sum = 8'(dic) + IPG - 8'(t);
  always_comb begin
    term_ctrl = '0;
    term_data = '0;
    for (int i = 0; i < 4; i++) begin
      term_ctrl[i]        = 3'(i) >= v;
      term_data[8*i +: 8] = 3'(i) < v ? s_data[8*i +: 8] : 3'(i) == v ? 8'hFD : 8'h07;
    end
  end
  always_comb begin
    state_nx = state;
    dic_nx   = dic;
    ipg_nx   = ipg_cnt;
    data_nx  = tx.data;
    ctrl_nx  = tx.ctrl;
    term     = 1'b0;
    done_nx  = 1'b0;
    urun_nx  = 1'b0;
    fram_nx  = 1'b0;
    if (ena) begin
      data_nx = IDLE_W;
      ctrl_nx = 4'hF;
      case (state)
        IDLE: begin
          fram_nx = s_valid & !s_sop;
          if (s_valid & s_sop & ipg_cnt == 8'd0) begin
            data_nx  = 32'h555555FB;
            ctrl_nx  = 4'b0001;
            state_nx = PRE;
          end
        end
        PRE: begin
          data_nx  = 32'hD5555555;
          ctrl_nx  = 4'b0000;
          state_nx = DATA;
        end
        DATA: begin
          if (!s_valid) begin
            data_nx  = 32'hFEFEFEFE;
            urun_nx  = 1'b1;
            state_nx = DROP;
          end else if (s_eop & s_empty != 2'd0) begin
            data_nx = term_data;
            ctrl_nx = term_ctrl;
            term    = 1'b1;
          end else begin
            data_nx  = s_data;
            ctrl_nx  = 4'b0000;
            state_nx = s_eop ? TERM : DATA;
          end
        end
        TERM: begin
          data_nx = 32'h070707FD;
          term    = 1'b1;
        end
        GAP: begin
          ipg_nx   = ipg_cnt == 8'd0 ? 8'd0 : ipg_cnt - 8'd1;
          state_nx = ipg_cnt <= 8'd1 ? IDLE : GAP;
        end
        DROP: if (s_valid & s_eop) begin
          ipg_nx   = IPG_W;
          dic_nx   = 2'd0;
          state_nx = GAP;
        end
        default: state_nx = IDLE;
      endcase
      if (term) begin
        done_nx  = 1'b1;
        ipg_nx   = {2'b0, sum[7:2]};
        dic_nx   = sum[1:0];
        state_nx = sum[7:2] == 6'd0 ? IDLE : GAP;
      end
    end
  end
  always_ff @(posedge clk_tx) begin
    if (rst) begin
      state        <= IDLE;
      dic          <= 2'd0;
      ipg_cnt      <= 8'd0;
      tx           <= '{ena: 1'b0, ctrl: 4'hF, data: IDLE_W};
      frame_done   <= 1'b0;
      err_underrun <= 1'b0;
      err_framing  <= 1'b0;
    end else begin
      state        <= state_nx;
      dic          <= dic_nx;
      ipg_cnt      <= ipg_nx;
      tx           <= '{ena: ena, ctrl: ctrl_nx, data: data_nx};
      frame_done   <= done_nx;
      err_underrun <= urun_nx;
      err_framing  <= fram_nx;
    end
  end
endmodule

// File: tb/tb_xgmii_tx_32b_framer.sv
// tb_xgmii_tx_32b_framer: directed frames checking words, gaps/DIC, stall, underrun, framing and reset
module tb_xgmii_tx_32b_framer;
  import gtype::*;
  localparam logic [31:0] IDLE_W = 32'h07070707;
  logic        clk_tx = 1'b0, rst = 1'b1, ena = 1'b0;
  logic        s_valid = 1'b0, s_sop = 1'b0, s_eop = 1'b0, s_ready;
  logic [31:0] s_data = '0;
  logic [1:0]  s_empty = '0;
  logic        frame_done, err_underrun, err_framing;
  xgmii32_t    tx;
  int          n_assert = 0, n_fail = 0;

  always #5 clk_tx = ~clk_tx;

  xgmii_tx_32b_framer #(.IPG_BYTES(12)) dut (
    .clk_tx(clk_tx), .rst(rst), .ena(ena), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .s_sop(s_sop), .s_eop(s_eop), .s_empty(s_empty), .tx(tx),
    .frame_done(frame_done), .err_underrun(err_underrun), .err_framing(err_framing)
  );

  task automatic tick();
    @(posedge clk_tx);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic v, input logic sop, input logic eop, input logic [1:0] emp, input logic [31:0] d);
    s_valid = v;
    s_sop   = sop;
    s_eop   = eop;
    s_empty = emp;
    s_data  = d;
  endtask

  task automatic word(input string tag, input logic [31:0] d, input logic [3:0] c, input logic fd);
    chk(tag, {26'b0, tx.ena, tx.ctrl, tx.data, frame_done}, {26'b0, 1'b1, c, d, fd});
  endtask

  // Drives one frame and checks its gap length (idle words before start), words and terminate
  task automatic frame(input int nb, input logic [1:0] emp, input logic [31:0] d0,
                       input logic [31:0] tw, input logic [3:0] tc, input int exp_idle,
                       input int stall_at, input int urun_at);
    int          idles = 0;
    bit          drop = 0;
    logic [31:0] d;
    put(1'b1, 1'b1, nb == 1, nb == 1 ? emp : 2'd0, d0);
    #1 chk("rdy_sop_idle", 64'(s_ready), 64'd0);
    for (int n = 0; n < 20; n++) begin
      tick();
      if (tx.data === 32'h555555FB && tx.ctrl === 4'b0001) break;
      word("gap_idle", IDLE_W, 4'hF, 1'b0);
      idles++;
    end
    chk("gap_len", 64'(idles), 64'(exp_idle));
    word("start", 32'h555555FB, 4'b0001, 1'b0);
    chk("rdy_pre", 64'(s_ready), 64'd0);
    tick();
    word("pre", 32'hD5555555, 4'h0, 1'b0);
    for (int b = 0; b < nb; b++) begin
      d = d0 + 32'(b) * 32'h04040404;
      if (b == stall_at) begin
        ena = 1'b0;
        #1 chk("rdy_stall", 64'(s_ready), 64'd0);
        tick();
        chk("stall", 64'({tx.ena, tx.ctrl, tx.data}), 64'({1'b0, 4'h0, d - 32'h04040404}));
        ena = 1'b1;
      end
      if (b == urun_at) begin
        s_valid = 1'b0;
        tick();
        chk("urun", 64'({tx.ctrl, tx.data, err_underrun, frame_done}), 64'({4'hF, 32'hFEFEFEFE, 2'b10}));
        drop = 1;
      end
      put(1'b1, b == 0, b == nb - 1, b == nb - 1 ? emp : 2'd0, d);
      #1 chk("rdy_beat", 64'(s_ready), 64'd1);
      tick();
      if (drop) chk("drop", 64'({tx.ctrl, tx.data, err_underrun, frame_done}), 64'({4'hF, IDLE_W, 2'b00}));
      else if (b == nb - 1 && emp != 2'd0) word("mterm", tw, tc, 1'b1);
      else word("data", d, 4'h0, 1'b0);
    end
    put(1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
    if (!drop && emp == 2'd0) begin
      tick();
      word("term", tw, tc, 1'b1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tick();
    tick();
    chk("rst_tx", 64'(tx), 64'({1'b0, 4'hF, IDLE_W}));
    chk("rst_pulses", 64'({frame_done, err_underrun, err_framing}), 64'd0);
    rst = 1'b0;
    ena = 1'b1;
    #1 chk("rdy_idle", 64'(s_ready), 64'd0);
    tick();
    word("idle_after_rst", IDLE_W, 4'hF, 1'b0);
    // basic frame, then back-to-back frames exercising the DIC cycle
    frame(2, 2'd0, 32'h04030201, 32'h070707FD, 4'hF, 0, -1, -1);
    frame(2, 2'd3, 32'h14131211, 32'h0707FD15, 4'b1110, 2, -1, -1);
    frame(1, 2'd3, 32'hA0A1A2A3, 32'h0707FDA3, 4'b1110, 2, -1, -1);
    frame(3, 2'd3, 32'h20202020, 32'h0707FD28, 4'b1110, 2, -1, -1);
    frame(2, 2'd3, 32'h30303030, 32'h0707FD34, 4'b1110, 2, -1, -1);
    frame(2, 2'd1, 32'h44332211, 32'hFD372615, 4'b1000, 3, -1, -1);
    frame(1, 2'd2, 32'hDDCCBBAA, 32'h07FDBBAA, 4'b1100, 2, -1, -1);
    // one-slot stall mid-frame
    frame(3, 2'd0, 32'h50505050, 32'h070707FD, 4'hF, 3, 1, -1);
    // underrun then clean frame after the fixed gap
    frame(3, 2'd0, 32'h60606060, 32'h070707FD, 4'hF, 2, -1, 1);
    frame(1, 2'd0, 32'h70717273, 32'h070707FD, 4'hF, 3, -1, -1);
    repeat (4) tick();
    put(1'b1, 1'b0, 1'b1, 2'd0, 32'hDEADBEEF);
    #1 chk("rdy_nosop", 64'(s_ready), 64'd1);
    tick();
    chk("framing", 64'({tx.ctrl, tx.data, err_framing}), 64'({4'hF, IDLE_W, 1'b1}));
    put(1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
    tick();
    chk("framing_pulse", 64'(err_framing), 64'd0);
    // leaves dic = 3 so a reset that fails to clear it lengthens the next gap
    frame(2, 2'd1, 32'h80818283, 32'hFD858687, 4'b1000, 0, -1, -1);
    repeat (3) tick();
    put(1'b1, 1'b1, 1'b0, 2'd0, 32'h90909090);
    tick();
    word("rst_start", 32'h555555FB, 4'b0001, 1'b0);
    tick();
    word("rst_pre", 32'hD5555555, 4'h0, 1'b0);
    tick();
    word("rst_data", 32'h90909090, 4'h0, 1'b0);
    put(1'b1, 1'b0, 1'b1, 2'd0, 32'h94949494);
    rst = 1'b1;
    tick();
    chk("rst_mid", 64'({frame_done, tx}), 64'({1'b0, 1'b0, 4'hF, IDLE_W}));
    put(1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
    #1 chk("rdy_rst", 64'(s_ready), 64'd0);
    rst = 1'b0;
    frame(1, 2'd2, 32'hA1A2A3A4, 32'h07FDA3A4, 4'b1100, 0, -1, -1);
    frame(1, 2'd0, 32'hB0B1B2B3, 32'h070707FD, 4'hF, 2, -1, -1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
